// File: rtl/pdm_cic_pkg.sv
// Shared constants, types and helpers for the 8-channel PDM CIC decimator.
package pdm_cic_pkg;

  localparam int unsigned OUT_W     = 19;
  localparam int unsigned INT_W     = OUT_W + 1;
  localparam int unsigned ORDER     = 3;
  localparam int unsigned DECIM     = 64;
  localparam int unsigned PDM_HALF  = 8;
  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned NUM_CH    = 2 * NUM_LINES;

  localparam int unsigned PH_W  = $clog2(2 * PDM_HALF);
  localparam int unsigned CNT_W = $clog2(DECIM);

  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(PDM_HALF - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(PDM_HALF);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * PDM_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  localparam logic [OUT_W-1:0] SAT_MAX = 19'h3FFFF;
  localparam logic [OUT_W-1:0] SAT_MIN = 19'h40000;

  typedef logic signed [OUT_W-1:0] pcm_t;
  typedef logic signed [INT_W-1:0] acc_t;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_e;

  function automatic int unsigned chan_idx(input int unsigned line, input edge_e edg);
    return 2 * line + ((edg == EDGE_FALL) ? 1 : 0);
  endfunction

endpackage

// File: rtl/pdm_cic_decimator_cic_channel.sv
// One CIC decimator channel: ORDER integrators, decimation register,
// ORDER combs (differential delay 1) and an OUT_W saturator.
module cic_channel
  import pdm_cic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic pdm_bit,
  input  logic decim_en,
  output pcm_t pcm
);

  acc_t integ    [ORDER];
  acc_t comb_dly [ORDER];
  acc_t comb_in  [ORDER];
  acc_t decim_q;
  acc_t comb_out;
  acc_t x;
  logic comb_en;

  assign x = pdm_bit ? acc_t'(1) : '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ORDER; i++) begin
        integ[i]    <= '0;
        comb_dly[i] <= '0;
      end
      decim_q <= '0;
      comb_en <= 1'b0;
    end else begin
      comb_en <= 1'b0;
      if (sample_en) begin
        integ[0] <= integ[0] + x;
        for (int unsigned i = 1; i < ORDER; i++)
          integ[i] <= integ[i] + integ[i-1];
        if (decim_en) begin
          decim_q <= integ[ORDER-1];
          comb_en <= 1'b1;
        end
      end
      if (comb_en) begin
        for (int unsigned i = 0; i < ORDER; i++)
          comb_dly[i] <= comb_in[i];
      end
    end
  end

  always_comb begin
    acc_t acc;
    acc = decim_q;
    for (int unsigned i = 0; i < ORDER; i++) begin
      comb_in[i] = acc;
      acc        = acc - comb_dly[i];
    end
    comb_out = acc;
  end

  // INT_W is OUT_W+1, so the value fits OUT_W exactly when the top two bits agree.
  always_comb begin
    if (comb_out[INT_W-1] == comb_out[INT_W-2])
      pcm = comb_out[OUT_W-1:0];
    else if (comb_out[INT_W-1])
      pcm = SAT_MIN;
    else
      pcm = SAT_MAX;
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// Four stereo PDM lines -> eight 19-bit PCM channels with a shared pcm_valid.
// Optional PDM_FRAME_CNT_EN adds a 16-bit frame_cnt output.
module pdm_cic_decimator
  import pdm_cic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  output logic                    pdm_clk,
  input  logic [NUM_LINES-1:0]    pdm_data,
  output logic signed [OUT_W-1:0] pcm_data_0,
  output logic signed [OUT_W-1:0] pcm_data_1,
  output logic signed [OUT_W-1:0] pcm_data_2,
  output logic signed [OUT_W-1:0] pcm_data_3,
  output logic signed [OUT_W-1:0] pcm_data_4,
  output logic signed [OUT_W-1:0] pcm_data_5,
  output logic signed [OUT_W-1:0] pcm_data_6,
  output logic signed [OUT_W-1:0] pcm_data_7,
  output logic                    pcm_valid
`ifdef PDM_FRAME_CNT_EN
  ,
  output logic [15:0]             frame_cnt
`endif
);

  logic [PH_W-1:0]  ph;
  logic [PH_W-1:0]  ph_next;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       sample_en;
  logic [1:0]       decim_en;
  logic [1:0]       done_q;
  pcm_t             ch_pcm    [NUM_CH];
  pcm_t             rise_hold [NUM_LINES];
  pcm_t             pcm_q     [NUM_CH];

  assign ph_next = (ph == PH_LAST) ? '0 : ph + PH_W'(1);

  assign sample_en[EDGE_RISE] = (ph == PH_RISE);
  assign sample_en[EDGE_FALL] = (ph == PH_LAST);
  assign decim_en[EDGE_RISE]  = (cnt[EDGE_RISE] == CNT_LAST);
  assign decim_en[EDGE_FALL]  = (cnt[EDGE_FALL] == CNT_LAST);

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    cic_channel u_rise (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en[EDGE_RISE]),
      .pdm_bit   (pdm_data[l]),
      .decim_en  (decim_en[EDGE_RISE]),
      .pcm       (ch_pcm[chan_idx(l, EDGE_RISE)])
    );
    cic_channel u_fall (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en[EDGE_FALL]),
      .pdm_bit   (pdm_data[l]),
      .decim_en  (decim_en[EDGE_FALL]),
      .pcm       (ch_pcm[chan_idx(l, EDGE_FALL)])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph        <= '0;
      pdm_clk   <= 1'b0;
      done_q    <= '0;
      pcm_valid <= 1'b0;
      for (int unsigned e = 0; e < 2; e++)
        cnt[e] <= '0;
      for (int unsigned l = 0; l < NUM_LINES; l++)
        rise_hold[l] <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++)
        pcm_q[k] <= '0;
    end else begin
      ph        <= ph_next;
      pdm_clk   <= (ph_next >= PH_HALF);
      done_q    <= sample_en & decim_en;
      pcm_valid <= done_q[EDGE_FALL];
      for (int unsigned e = 0; e < 2; e++) begin
        if (sample_en[e])
          cnt[e] <= decim_en[e] ? '0 : cnt[e] + CNT_W'(1);
      end
      // Rise chain finishes half a PDM period early; park it until the fall chain lands.
      if (done_q[EDGE_RISE]) begin
        for (int unsigned l = 0; l < NUM_LINES; l++)
          rise_hold[l] <= ch_pcm[chan_idx(l, EDGE_RISE)];
      end
      if (done_q[EDGE_FALL]) begin
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
          pcm_q[chan_idx(l, EDGE_RISE)] <= rise_hold[l];
          pcm_q[chan_idx(l, EDGE_FALL)] <= ch_pcm[chan_idx(l, EDGE_FALL)];
        end
      end
    end
  end

`ifdef PDM_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= '0;
    else if (done_q[EDGE_FALL])
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

  assign pcm_data_0 = pcm_q[0];
  assign pcm_data_1 = pcm_q[1];
  assign pcm_data_2 = pcm_q[2];
  assign pcm_data_3 = pcm_q[3];
  assign pcm_data_4 = pcm_q[4];
  assign pcm_data_5 = pcm_q[5];
  assign pcm_data_6 = pcm_q[6];
  assign pcm_data_7 = pcm_q[7];

endmodule
